sram_pattern_checker: RTL
=========================

Name: sram_pattern_checker

Overview:
Read-side counterpart of the SRAM test pattern generator. It consumes the read-back word stream for one full pass over the SRAM and compares every word against the expected pattern for the selected test state. It counts mismatches, captures the first failure, and reports pass completion. It sits between the SRAM read controller and the test top / UART reporter.

Parameters:
DATA_BITS, 16, width of the SRAM data word; must be even.
ADDR_BITS, 20, width of the SRAM address; a pass covers addresses 0 to 2^ADDR_BITS-1.
ERR_CNT_BITS, 16, width of the saturating error counter.

Ports:
clk  input  1  system clock
reset  input  1  synchronous, active-high reset
start  input  1  one-cycle pulse that begins a pass and latches pattern_sel and custom
pattern_sel  input  3  test state code: 0 zeros, 1 ones, 2 alt 10, 3 alt 01, 4 half ones, 5 zeros again, 6 custom, 7 zeros
custom  input  DATA_BITS  custom pattern, used when pattern_sel is 6
rd_valid  input  1  rd_addr and rd_data are valid this cycle
rd_addr  input  ADDR_BITS  address of the read-back word
rd_data  input  DATA_BITS  read-back word
busy  output  1  high while a pass is in progress
pass_done  output  1  one-cycle pulse when a pass completes
error  output  1  sticky flag: at least one mismatch this pass
err_count  output  ERR_CNT_BITS  mismatch count for this pass, saturating
first_err_addr  output  ADDR_BITS  address of the first mismatch
first_err_data  output  DATA_BITS  data read at the first mismatch
first_err_expected  output  DATA_BITS  expected value at the first mismatch
addr_error  output  1  sticky address-sequence fault (see Optional Feature)

Behaviour:
- Reset values: state IDLE; busy, pass_done, error and addr_error are 0; err_count, first_err_addr, first_err_data and first_err_expected are 0.
- State machine: IDLE, CHECK, DONE.
- IDLE: when start=1, latch the expected pattern from pattern_sel and custom, clear all result outputs, set busy=1 next cycle, and go to CHECK. rd_valid is ignored in IDLE, including in the cycle start is asserted.
- CHECK, on each rd_valid beat:
  - compare rd_data with the latched expected value;
  - on mismatch, increment err_count, saturating at all ones, and set error;
  - if this is the first mismatch (error was 0), capture rd_addr, rd_data and the expected value.
- Latency: results are registered. A beat in cycle N is reflected in the outputs in cycle N+1.
- CHECK exit: a beat with rd_addr equal to all ones is the final beat. It is checked normally, then the block goes to DONE.
- DONE: lasts one cycle. pass_done=1, busy=0, then the block returns to IDLE. Results hold until the next start.
- start while in CHECK or DONE: the current pass is aborted, and the block restarts exactly as from IDLE (re-latch and clear). No pass_done is issued for the aborted pass.
- The expected value does not change mid-pass, even if pattern_sel or custom change.
- Reset asserted mid-pass: everything returns to reset values on the next edge, and the pass is abandoned.
- Pattern values: identical to the generator.
  - alt 10 = {DATA_BITS/2{2'b10}}
  - alt 01 = {DATA_BITS/2{2'b01}}
  - half ones = all ones >> DATA_BITS/2 (low half ones)

Optional Feature:
SRAM_PATTERN_CHECKER_ADDR_SEQ_EN.
- Defined: the checker keeps an expected-address counter, reset to 0 at start.
  - Each CHECK beat compares rd_addr with the counter, then increments the counter.
  - A mismatch sets addr_error (sticky until the next start or reset).
  - The data compare still proceeds.
- Undefined: no counter; addr_error is tied to 0.

Decomposition:
- Shared package sram_test_pkg holds the 3-bit state codes, the pattern constants (a function of DATA_BITS), and a function expected_pattern(sel, custom). The generator and the checker share these definitions.
- One natural combinational sub-module: sram_pattern_expected (sel, custom -> pattern).

Test Plan:
- All-ones pass with ADDR_BITS=4: start with sel=1 and 16 beats of 0xFFFF. Expect pass_done one cycle after the addr-15 beat, error=0, err_count=0.
- Single fault: sel=2 and 16 beats, with addr 5 returning 0xAAAB. Expect err_count=1, first_err_addr=5, first_err_data=0xAAAB, first_err_expected=0xAAAA.
- Saturation: ERR_CNT_BITS=2, sel=0, all 16 beats 0x0001. Expect err_count=3, and first_err_addr=0.
- Custom and restart: sel=6 with custom=0x1234 and 3 good beats, then start with sel=4. Expect cleared results and expected value 0x00FF, with no pass_done for the aborted pass.
- Reset and IDLE: a beat coincident with start is ignored; reset at beat 7 leaves busy=0 and err_count=0.
- With the macro defined: beat addresses 0, 1, 3 set addr_error at the third beat. With it undefined, addr_error stays 0.

Source files
------------

// File: rtl/sram_test_pkg.sv
// sram_test_pkg
// Definitions shared by the SRAM test pattern generator and checker: the
// 3-bit test state codes, the checker FSM state type, and expected_pattern(),
// which builds the data word for a test state at any width up to
// MAX_DATA_BITS.
// Ports: none (package).

package sram_test_pkg;

    // Widest data word the pattern helper can build.
    localparam int unsigned MAX_DATA_BITS = 64;

    typedef enum logic [2:0] {
        SelZeros    = 3'd0,
        SelOnes     = 3'd1,
        SelAlt10    = 3'd2,
        SelAlt01    = 3'd3,
        SelHalfOnes = 3'd4,
        SelZerosB   = 3'd5,
        SelCustom   = 3'd6,
        SelZerosC   = 3'd7
    } test_sel_e;

    typedef enum logic [1:0] {
        StIdle,
        StCheck,
        StDone
    } chk_state_e;

    // Pattern for test state 'sel' at width 'data_bits'. Bits at and above
    // data_bits are zero. alt 10 puts ones on odd bits, alt 01 on even bits,
    // half ones fills the low data_bits/2 bits.
    function automatic logic [MAX_DATA_BITS-1:0] expected_pattern(
        input int unsigned              data_bits,
        input logic [2:0]               sel,
        input logic [MAX_DATA_BITS-1:0] custom
    );
        logic [MAX_DATA_BITS-1:0] pat;
        pat = '0;
        for (int unsigned i = 0; i < MAX_DATA_BITS; i++) begin
            if (i < data_bits) begin
                case (test_sel_e'(sel))
                    SelOnes:     pat[i] = 1'b1;
                    SelAlt10:    pat[i] = ((i % 2) == 1);
                    SelAlt01:    pat[i] = ((i % 2) == 0);
                    SelHalfOnes: pat[i] = (i < (data_bits / 2));
                    SelCustom:   pat[i] = custom[i];
                    default:     pat[i] = 1'b0;
                endcase
            end
        end
        return pat;
    endfunction

endpackage

// File: rtl/sram_pattern_checker_if.sv
// sram_pattern_checker_if
// Read-back word stream from the SRAM read controller into the checker.
// Signals:
//   rd_valid  rd_addr/rd_data are valid this cycle
//   rd_addr   address of the read-back word (ADDR_BITS)
//   rd_data   read-back word (DATA_BITS)
// Modports: master (read controller, drives), slave (checker, samples).

interface sram_pattern_checker_if #(
    parameter int unsigned DATA_BITS = 16,
    parameter int unsigned ADDR_BITS = 20
);
    logic                 rd_valid;
    logic [ADDR_BITS-1:0] rd_addr;
    logic [DATA_BITS-1:0] rd_data;

    modport master (output rd_valid, output rd_addr, output rd_data);
    modport slave  (input  rd_valid, input  rd_addr, input  rd_data);
endinterface

// File: rtl/sram_pattern_expected.sv
// sram_pattern_expected
// Combinational expected-pattern lookup for a test state code.
// Ports:
//   sel      in   3-bit test state code
//   custom   in   custom pattern, used for state 6
//   pattern  out  expected data word
// DATA_BITS must be even and below MAX_DATA_BITS.

module sram_pattern_expected
    import sram_test_pkg::*;
#(
    parameter int unsigned DATA_BITS = 16
) (
    input  logic [2:0]           sel,
    input  logic [DATA_BITS-1:0] custom,
    output logic [DATA_BITS-1:0] pattern
);
    logic [MAX_DATA_BITS-1:0] custom_wide;
    logic [MAX_DATA_BITS-1:0] pattern_wide;
    logic                     unused_upper;

    assign custom_wide  = MAX_DATA_BITS'(custom);
    assign pattern_wide = expected_pattern(DATA_BITS, sel, custom_wide);
    assign pattern      = pattern_wide[DATA_BITS-1:0];

    // Upper bits are always zero; fold them away.
    assign unused_upper = ^pattern_wide[MAX_DATA_BITS-1:DATA_BITS];
endmodule

// File: rtl/sram_pattern_checker.sv
// sram_pattern_checker
// Checks one full read-back pass of the SRAM against the pattern of the
// selected test state. Counts mismatches (saturating), captures the first
// failure and pulses pass_done after the beat at the last address.
// Ports:
//   clk, reset          clock, synchronous active-high reset
//   start               pulse: (re)start a pass, latch pattern_sel/custom
//   pattern_sel,custom  test state code and custom pattern
//   rd                  read-back stream (sram_pattern_checker_if.slave)
//   busy, pass_done     pass in progress / one-cycle completion pulse
//   error, err_count    sticky mismatch flag / saturating mismatch count
//   first_err_*         address, data and expected value of first mismatch
//   addr_error          sticky address-sequence fault
// Optional: define SRAM_PATTERN_CHECKER_ADDR_SEQ_EN to check that beat
// addresses run 0, 1, 2, ...; otherwise addr_error is tied to 0.

module sram_pattern_checker
    import sram_test_pkg::*;
#(
    parameter int unsigned DATA_BITS    = 16,
    parameter int unsigned ADDR_BITS    = 20,
    parameter int unsigned ERR_CNT_BITS = 16
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    start,
    input  logic [2:0]              pattern_sel,
    input  logic [DATA_BITS-1:0]    custom,
    sram_pattern_checker_if.slave   rd,
    output logic                    busy,
    output logic                    pass_done,
    output logic                    error,
    output logic [ERR_CNT_BITS-1:0] err_count,
    output logic [ADDR_BITS-1:0]    first_err_addr,
    output logic [DATA_BITS-1:0]    first_err_data,
    output logic [DATA_BITS-1:0]    first_err_expected,
    output logic                    addr_error
);
    chk_state_e state_q, state_d;

    logic [DATA_BITS-1:0]    pattern_now;
    logic [DATA_BITS-1:0]    expected_q;
    logic                    error_q;
    logic [ERR_CNT_BITS-1:0] err_count_q;
    logic [ADDR_BITS-1:0]    first_addr_q;
    logic [DATA_BITS-1:0]    first_data_q;
    logic [DATA_BITS-1:0]    first_exp_q;

    logic beat;
    logic last_beat;
    logic mismatch;

    sram_pattern_expected #(
        .DATA_BITS (DATA_BITS)
    ) u_expected (
        .sel     (pattern_sel),
        .custom  (custom),
        .pattern (pattern_now)
    );

    // A start wins over any beat in the same cycle: the pass restarts.
    assign beat      = (state_q == StCheck) && rd.rd_valid && !start;
    assign last_beat = beat && (rd.rd_addr == '1);
    assign mismatch  = beat && (rd.rd_data != expected_q);

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        busy      = (state_q == StCheck);
        pass_done = (state_q == StDone);
        if (start) begin
            state_d = StCheck;
        end else begin
            unique case (state_q)
                StIdle:  state_d = StIdle;
                StCheck: if (last_beat) state_d = StDone;
                StDone:  state_d = StIdle;
                default: state_d = StIdle;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset || start) begin
            expected_q   <= reset ? '0 : pattern_now;
            error_q      <= 1'b0;
            err_count_q  <= '0;
            first_addr_q <= '0;
            first_data_q <= '0;
            first_exp_q  <= '0;
        end else if (mismatch) begin
            error_q <= 1'b1;
            if (err_count_q != '1) begin
                err_count_q <= err_count_q + ERR_CNT_BITS'(1);
            end
            if (!error_q) begin
                first_addr_q <= rd.rd_addr;
                first_data_q <= rd.rd_data;
                first_exp_q  <= expected_q;
            end
        end
    end

    assign error              = error_q;
    assign err_count          = err_count_q;
    assign first_err_addr     = first_addr_q;
    assign first_err_data     = first_data_q;
    assign first_err_expected = first_exp_q;

`ifdef SRAM_PATTERN_CHECKER_ADDR_SEQ_EN
    logic [ADDR_BITS-1:0] exp_addr_q;
    logic                 addr_error_q;

    always_ff @(posedge clk) begin
        if (reset || start) begin
            exp_addr_q   <= '0;
            addr_error_q <= 1'b0;
        end else if (beat) begin
            if (rd.rd_addr != exp_addr_q) begin
                addr_error_q <= 1'b1;
            end
            exp_addr_q <= exp_addr_q + ADDR_BITS'(1);
        end
    end

    assign addr_error = addr_error_q;
`else
    assign addr_error = 1'b0;
`endif
endmodule
